// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRP_DEF  = 3;

  // Register 0 is hardwired to zero and is never marked busy.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: an issue marks a destination as pending, and a
// writeback on either port clears it. If an issue and a write hit the
// same register in one cycle, the issue wins because it names a newer
// producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic            wa_valid,
  input  logic [AW-1:0]   wa_addr,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear on writes first, then set on issue so a same-cycle issue stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wa_valid) busy_d[wa_addr] = 1'b0;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (iss_valid) busy_d[iss_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy state register; reset overrides any same-cycle issue or write.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRP combinational read ports, two write ports
// (B wins on an address collision) and a busy-bit scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN forwards in-flight write data
// to the read ports in the same cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRP  = NRP_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wa_valid,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREG];

  // Storage update; port B is applied after port A so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wa_valid && wa_addr != ZERO_ADDR) regs[wa_addr] <= wa_data;
      if (wb_valid && wb_addr != ZERO_ADDR) regs[wb_addr] <= wb_data;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid && iss_addr != ZERO_ADDR),
    .iss_addr  (iss_addr),
    .wa_valid  (wa_valid),
    .wa_addr   (wa_addr),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .busy_vec  (busy_vec)
  );

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[k*AW +: AW];

    // Per-port read mux, optionally forwarding same-cycle write data.
    always_comb begin
      data = (addr == ZERO_ADDR) ? '0 : regs[addr];
      busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
      if (addr != ZERO_ADDR && ((wa_valid && wa_addr == addr) ||
                                (wb_valid && wb_addr == addr))) begin
        data = (wb_valid && wb_addr == addr) ? wb_data : wa_data;
        busy = iss_valid && iss_addr == addr;
      end
`endif
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter NREG, default 32, register count (power of 2, >=2); AW = $clog2(NREG).
REQ-003 Parameter NRP, default 3, number of combinational read ports.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rd_addr  in  NRP*AW  read addresses, port k at bits [k*AW +: AW].
REQ-007 rd_data  out  NRP*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-008 rd_busy  out  NRP  per-port busy flag of the addressed register.
REQ-009 wa_valid/wa_addr/wa_data  in  1/AW/XLEN  write port A (main writeback).
REQ-010 wb_valid/wb_addr/wb_data  in  1/AW/XLEN  write port B (predicted-path writeback).
REQ-011 iss_valid/iss_addr  in  1/AW  issue port; marks a destination as pending.
REQ-012 busy_vec  out  NREG  scoreboard state, bit i = register i pending.

Function
REQ-013 Register 0 SHALL read as zero on every port and SHALL ignore all writes and issues.
REQ-014 rd_data SHALL be a combinational function of rd_addr and current state, zero cycles latency.
REQ-015 A write on a valid port with addr != 0 SHALL update the register at the next rising edge.
REQ-016 Both write ports same cycle, different addresses: both registers SHALL update.
REQ-017 Both write ports same cycle, same address: port B data SHALL be stored, port A data discarded.
REQ-018 Scoreboard: iss_valid with iss_addr != 0 SHALL set busy_vec[iss_addr] at the next edge.
REQ-019 Any valid write (A or B) to register r SHALL clear busy_vec[r] at the next edge.
REQ-020 Issue and write to the same register in one cycle: set SHALL win (new producer pending), write data still stored.
REQ-021 Issue to an already-busy register SHALL leave it busy (no counting); one write clears it.
REQ-022 rd_busy[k] SHALL equal busy_vec[rd_addr port k] after the bypass rule of REQ-026/027.
REQ-023 busy_vec[0] SHALL be constant 0.

Reset
REQ-024 rst high at a rising edge SHALL clear all registers to 0 and all busy bits to 0, overriding any same-cycle write or issue.
REQ-025 During rst, rd_data SHALL reflect pre-reset contents until the edge; after the edge all ports read 0 and rd_busy = 0.

Configuration
REQ-026 With REGFILE_BYPASS_EN defined: a read of register r != 0 while a valid write to r is presented SHALL return the write data combinationally (port B over A per REQ-017) and rd_busy SHALL read 0 unless iss_valid targets r the same cycle.
REQ-027 Without REGFILE_BYPASS_EN: reads SHALL return stored contents only; rd_busy reflects busy_vec unmodified.

Structure
REQ-028 Package regfile_pkg SHALL hold default XLEN/NREG/NRP constants and the zero-register index constant.
REQ-029 Busy tracking SHALL be a sub-module regfile_scoreboard (inputs issue and both write ports, output busy_vec); storage and read muxing stay in regfile_mp.

Verification
REQ-030 Reset then read all ports at addrs 0,5,31 -> rd_data 0, rd_busy 0, busy_vec 0.
REQ-031 wa write r5=0xDEADBEEF, wb write r5=0x12345678 same cycle -> next cycle r5 reads 0x12345678; wa to r0=0xFFFFFFFF -> r0 reads 0.
REQ-032 iss r7; next cycle busy_vec[7]=1; wa write r7=0xA5 -> following cycle busy_vec[7]=0, r7=0xA5; iss r7 and wb r7=0x3C same cycle -> r7=0x3C, busy_vec[7]=1.
REQ-033 With REGFILE_BYPASS_EN: r9=0x11 stored, wa writes r9=0x22, port 1 reads r9 same cycle -> 0x22, rd_busy[1]=0; without macro -> 0x11.
REQ-034 rst asserted same cycle as wa write r3=0x55 and iss r4 -> after edge r3=0, busy_vec[4]=0.
REQ-035 NREG=16, XLEN=64, NRP=4 build: write r15=0xFFFF_FFFF_FFFF_FFFF -> all four ports addressing r15 read it back.
